// File: rtl/apu_arb_pkg.sv
// ----------------------------------------------------------------------------
// apu_arb_pkg
// Types for the shared-APU round-robin arbiter.
// No ports; arbiter FSM state encoding only.
// ----------------------------------------------------------------------------
package apu_arb_pkg;
    // ARB : free round-robin selection among requesting cores
    // LOCK: an offered request was not granted; selection is pinned to it
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;
endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
// APU interface widths shared between the cv32e40p core and the APU/FPU.
// No ports; constants only.
// ----------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;
    localparam int APU_NARGS_CPU    = 3;   // operands per APU operation
    localparam int APU_WOP_CPU      = 6;   // opcode width
    localparam int APU_NDSFLAGS_CPU = 15;  // downstream (core -> APU) flags
    localparam int APU_NUSFLAGS_CPU = 5;   // upstream (APU -> core) flags
endpackage

// File: rtl/apu_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// apu_rr_arbiter_if
// Request/response channel between the arbiter and the shared APU.
//   req/gnt      : request handshake. A request transfers in the cycle where
//                  req and gnt are both 1. While req is 1 and gnt is 0 the
//                  operands/op/flags are held stable and req stays high.
//   rvalid       : one response, accepted unconditionally (no back-pressure);
//                  result/rflags are only meaningful when rvalid is 1.
// Modports: master = arbiter side, slave = APU side.
// ----------------------------------------------------------------------------
interface apu_rr_arbiter_if;
    import cv32e40p_apu_core_pkg::*;

    logic                             req;
    logic                             gnt;
    logic [APU_NARGS_CPU*32-1:0]      operands;
    logic [APU_WOP_CPU-1:0]           op;
    logic [APU_NDSFLAGS_CPU-1:0]      flags;
    logic                             rvalid;
    logic [31:0]                      result;
    logic [APU_NUSFLAGS_CPU-1:0]      rflags;

    modport master (
        output req, operands, op, flags,
        input  gnt, rvalid, result, rflags
    );

    modport slave (
        input  req, operands, op, flags,
        output gnt, rvalid, result, rflags
    );
endinterface

// File: rtl/apu_tag_fifo.sv
// ----------------------------------------------------------------------------
// apu_tag_fifo
// Synchronous FIFO holding requester IDs of granted, unanswered operations.
// Ports: clk_i, rst_ni (async active-low), push/din, pop/dout,
//        full, empty, count (occupancy).
// DEPTH must be a power of two so the pointers wrap naturally.
// Push when full and pop when empty are ignored.
// ----------------------------------------------------------------------------
module apu_tag_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind valid occupancy.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// apu_rr_arbiter
// Shares one APU between NUM_REQ cores. Round-robin request arbitration,
// selection locked while an offered request waits for its grant, responses
// routed back in grant order through a tag FIFO.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   req_i/gnt_o            per-core request handshake
//   operands_i/op_i/flags_i per-core request payload (core k at slice k)
//   rvalid_o               per-core response strobe
//   result_o/rflags_o      broadcast response payload, qualified by rvalid_o
//   apu                    shared-APU channel (master side)
//   outstanding_o          tag FIFO occupancy
//   err_o                  sticky protocol error (cleared by reset only)
//   state_o                arbiter FSM state
// ----------------------------------------------------------------------------
module apu_rr_arbiter
    import cv32e40p_apu_core_pkg::*;
    import apu_arb_pkg::*;
#(
    parameter  int NUM_REQ         = 2,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int IDW             = $clog2(NUM_REQ),
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1),
    localparam int OPW             = APU_NARGS_CPU * 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ-1:0]                    req_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    input  logic [NUM_REQ*OPW-1:0]                operands_i,
    input  logic [NUM_REQ*APU_WOP_CPU-1:0]        op_i,
    input  logic [NUM_REQ*APU_NDSFLAGS_CPU-1:0]   flags_i,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic [31:0]                           result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]           rflags_o,
    apu_rr_arbiter_if.master                      apu,
    output logic [CW-1:0]                         outstanding_o,
    output logic                                  err_o,
    output arb_state_e                            state_o
);
    arb_state_e     state_q;
    arb_state_e     state_d;
    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] lock_q;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           hs;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           err_set;

    // First asserted request at or after rr_q, searching upward with wrap.
    always_comb begin
        int  idx;
        logic found;
        winner = rr_q;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign sel = (state_q == LOCK) ? lock_q : winner;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ARB;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:  if (apu.req && !apu.gnt) state_d = LOCK;
            LOCK: if (hs || !req_i[lock_q]) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // FSM: outputs. apu.req is gated by rst_ni so everything reads idle
    // while reset is held, even with cores still requesting.
    always_comb begin
        apu.req      = 1'b0;
        apu.operands = '0;
        apu.op       = '0;
        apu.flags    = '0;
        gnt_o        = '0;
        rvalid_o     = '0;
        if (rst_ni && !fifo_full) begin
            apu.req = (state_q == ARB) ? |req_i : req_i[lock_q];
        end
        hs = apu.req && apu.gnt;
        if (hs) gnt_o[sel] = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(sel) == k) begin
                apu.operands = operands_i[k*OPW +: OPW];
                apu.op       = op_i[k*APU_WOP_CPU +: APU_WOP_CPU];
                apu.flags    = flags_i[k*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];
            end
        end
        pop = apu.rvalid && !fifo_empty;
        if (pop) rvalid_o[head] = 1'b1;
        // Stray response, or a locked core withdrawing its request.
        err_set = (apu.rvalid && fifo_empty) ||
                  ((state_q == LOCK) && !req_i[lock_q]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= '0;
            err_o  <= 1'b0;
        end else begin
            if (state_q == ARB && apu.req && !apu.gnt) lock_q <= winner;
            if (hs) rr_q <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
            if (err_set) err_o <= 1'b1;
        end
    end

    // apu.req is already low when full, so hs never pushes into a full FIFO.
    apu_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (hs),
        .din    (sel),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outstanding_o)
    );

    assign result_o = apu.result;
    assign rflags_o = apu.rflags;
    assign state_o  = state_q;
endmodule

// File: tb/tb_apu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apu_rr_arbiter
// Directed bench for apu_rr_arbiter with NUM_REQ=2, MAX_OUTSTANDING=4.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
// ----------------------------------------------------------------------------
module tb_apu_rr_arbiter;
    import cv32e40p_apu_core_pkg::*;
    import apu_arb_pkg::*;

    localparam int OPW = APU_NARGS_CPU * 32;

    logic                         clk;
    logic                         rst_n;
    logic [1:0]                   req;
    logic [1:0]                   gnt;
    logic [2*OPW-1:0]             operands;
    logic [2*APU_WOP_CPU-1:0]     op;
    logic [2*APU_NDSFLAGS_CPU-1:0] flags;
    logic [1:0]                   rvalid;
    logic [31:0]                  result;
    logic [APU_NUSFLAGS_CPU-1:0]  rflags;
    logic [2:0]                   outstanding;
    logic                         err;
    arb_state_e                   st;

    logic [OPW-1:0]               ops0;
    logic [OPW-1:0]               ops1;
    logic [APU_WOP_CPU-1:0]       op0;
    logic [APU_WOP_CPU-1:0]       op1;
    logic [APU_NDSFLAGS_CPU-1:0]  fl0;

    int pass_cnt  = 0;
    int check_cnt = 0;

    apu_rr_arbiter_if apu_bus ();

    apu_rr_arbiter #(
        .NUM_REQ         (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .gnt_o         (gnt),
        .operands_i    (operands),
        .op_i          (op),
        .flags_i       (flags),
        .rvalid_o      (rvalid),
        .result_o      (result),
        .rflags_o      (rflags),
        .apu           (apu_bus.master),
        .outstanding_o (outstanding),
        .err_o         (err),
        .state_o       (st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] res);
        req            = r;
        apu_bus.gnt    = g;
        apu_bus.rvalid = rv;
        apu_bus.result = res;
        apu_bus.rflags = res[4:0];
    endtask

    logic [1:0] lp_req [10];
    logic [1:0] lp_gnt [10];
    logic [1:0] lp_rv  [10];

    initial begin
        ops0 = 96'h0000_0a0a_0000_0a0b_0000_0a0c;
        ops1 = 96'h0000_0b0a_0000_0b0b_0000_0b0c;
        op0  = 6'h15;
        op1  = 6'h2a;
        fl0  = 15'h0222;
        operands = {ops1, ops0};
        op       = {op1, op0};
        flags    = {15'h1111, fl0};
        lp_req = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11};
        lp_gnt = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};
        lp_rv  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

        // reset state
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        settle();
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_apu_req", apu_bus.req, 1'b0);
        check("rst_outstanding", outstanding, 3'd0);
        check("rst_err", err, 1'b0);
        check("rst_state", st, ARB);
        next_cycle();
        rst_n = 1'b1;

        // single request from core 0, response two cycles later
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        settle();
        check("t1_gnt", gnt, 2'b01);
        check("t1_apu_req", apu_bus.req, 1'b1);
        check("t1_op", apu_bus.op, op0);
        check("t1_operands", apu_bus.operands, ops0);
        check("t1_flags", apu_bus.flags, fl0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        settle();
        check("t1_outstanding1", outstanding, 3'd1);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'hcafe_0001);
        settle();
        check("t1_rvalid", rvalid, 2'b01);
        check("t1_result", result, 32'hcafe_0001);
        check("t1_rflags", rflags, 5'h01);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        settle();
        check("t1_outstanding0", outstanding, 3'd0);
        check("t1_rvalid_idle", rvalid, 2'b00);

        // both cores continuously; pointer starts at 1 after core 0's grant
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        settle();
        check("t2_gnt_a", gnt, 2'b10);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0b01);
        settle();
        check("t2_gnt_b", gnt, 2'b01);
        check("t2_rv_b", rvalid, 2'b10);
        check("t2_occ_b", outstanding, 3'd1);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0b02);
        settle();
        check("t2_gnt_c", gnt, 2'b10);
        check("t2_rv_c", rvalid, 2'b01);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_0b03);
        settle();
        check("t2_gnt_d", gnt, 2'b01);
        check("t2_rv_d", rvalid, 2'b10);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_0b04);
        settle();
        check("t2_rv_e", rvalid, 2'b01);
        check("t2_result_e", result, 32'h0000_0b04);

        // lock: core 0 offered without grant; core 1 joins but cannot preempt
        next_cycle();
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        settle();
        check("t3_req0", apu_bus.req, 1'b1);
        check("t3_gnt0", gnt, 2'b00);
        check("t3_ops0", apu_bus.operands, ops0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            drive(2'b11, 1'b0, 1'b0, 32'h0);
            settle();
            check("t3_state_lock", st, LOCK);
            check("t3_lock_ops", apu_bus.operands, ops0);
            check("t3_lock_op", apu_bus.op, op0);
            check("t3_lock_gnt", gnt, 2'b00);
        end
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        settle();
        check("t3_gnt_locked", gnt, 2'b01);
        next_cycle();
        settle();
        check("t3_state_arb", st, ARB);
        check("t3_gnt_next", gnt, 2'b10);
        check("t3_op_next", apu_bus.op, op1);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        settle();
        check("t3_occ2", outstanding, 3'd2);
        check("t3_rv_a", rvalid, 2'b01);
        next_cycle();
        settle();
        check("t3_rv_b", rvalid, 2'b10);

        // fill the tag FIFO: grants 0,1,0,1
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(2'b11, 1'b1, 1'b0, 32'h0);
            settle();
            check("t4_fill_gnt", gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
        end
        next_cycle();
        settle();
        check("t4_occ_full", outstanding, 3'd4);
        check("t4_full_req", apu_bus.req, 1'b0);
        check("t4_full_gnt", gnt, 2'b00);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 32'h0);
        settle();
        check("t4_nobypass_req", apu_bus.req, 1'b0);
        check("t4_nobypass_gnt", gnt, 2'b00);
        check("t4_pop_rv", rvalid, 2'b01);
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        settle();
        check("t4_occ3", outstanding, 3'd3);
        check("t4_req_back", apu_bus.req, 1'b1);
        check("t4_gnt_back", gnt, 2'b01);

        // drain to occupancy 2 (queued tags 1,0,1,0)
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        settle();
        check("t5_drain_a", rvalid, 2'b10);
        next_cycle();
        settle();
        check("t5_drain_b", rvalid, 2'b01);

        // 10 cycles of simultaneous grant and response at occupancy 2
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(lp_req[i], 1'b1, 1'b1, 32'h5000_0000 + 32'(i));
            settle();
            check("t5_occ", outstanding, 3'd2);
            check("t5_gnt", gnt, lp_gnt[i]);
            check("t5_rv", rvalid, lp_rv[i]);
            check("t5_result", result, 32'h5000_0000 + 32'(i));
        end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        settle();
        check("t5_occ_after", outstanding, 3'd2);
        check("t5_tail_a", rvalid, 2'b10);
        next_cycle();
        settle();
        check("t5_tail_b", rvalid, 2'b01);

        // stray response with empty FIFO
        next_cycle();
        settle();
        check("t6_empty_occ", outstanding, 3'd0);
        check("t6_stray_rv", rvalid, 2'b00);
        check("t6_err_before", err, 1'b0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        settle();
        check("t6_err_set", err, 1'b1);
        check("t6_occ_zero", outstanding, 3'd0);

        // asynchronous reset in the middle of traffic
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        settle();
        check("t6_pre_gnt", gnt, 2'b10);
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 2'b00);
        check("t6_rst_req", apu_bus.req, 1'b0);
        check("t6_rst_rv", rvalid, 2'b00);
        check("t6_rst_occ", outstanding, 3'd0);
        check("t6_rst_err", err, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 32'h0);

        // locked core withdraws its request without a grant
        next_cycle();
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        settle();
        check("t7_req", apu_bus.req, 1'b1);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        settle();
        check("t7_state_lock", st, LOCK);
        check("t7_err_before", err, 1'b0);
        next_cycle();
        settle();
        check("t7_err_set", err, 1'b1);
        check("t7_state_arb", st, ARB);
        check("t7_occ", outstanding, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/apu_rr_arbiter.md
Name: apu_rr_arbiter

Overview:
Shares one APU/FPU instance between NUM_REQ cv32e40p cores through the core's apu_req/apu_gnt/apu_rvalid handshake. Round-robin arbitration runs on the request channel. The request selection is locked while a request is pending and ungranted. Responses are routed back in grant order using a tag FIFO of issued requester IDs. The block sits between the core instances and the shared APU in the cluster-level wrapper.

Parameters:
NUM_REQ, 2, number of requesting cores (2..8)
MAX_OUTSTANDING, 4, tag FIFO depth = maximum granted-but-unanswered APU operations (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-core apu_req_o
gnt_o  out  NUM_REQ  per-core apu_gnt_i
operands_i  in  NUM_REQ*APU_NARGS_CPU*32  per-core operands, core k at slice k
op_i  in  NUM_REQ*APU_WOP_CPU  per-core opcode
flags_i  in  NUM_REQ*APU_NDSFLAGS_CPU  per-core downstream flags
rvalid_o  out  NUM_REQ  per-core apu_rvalid_i
result_o  out  32  broadcast result; qualified by rvalid_o
rflags_o  out  APU_NUSFLAGS_CPU  broadcast upstream flags; qualified by rvalid_o
apu_req_o  out  1  request to shared APU
apu_gnt_i  in  1  APU grant
apu_operands_o  out  APU_NARGS_CPU*32  selected operands
apu_op_o  out  APU_WOP_CPU  selected opcode
apu_flags_o  out  APU_NDSFLAGS_CPU  selected flags
apu_rvalid_i  in  1  APU response valid
apu_result_i  in  32  APU result
apu_flags_i  in  APU_NUSFLAGS_CPU  APU upstream flags
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current tag FIFO occupancy
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_ni=0): rr pointer=0, FSM=ARB, FIFO empty, err_o=0.
- Reset outputs: gnt_o=0, rvalid_o=0, apu_req_o=0, outstanding_o=0.
- FSM ARB:
  - Winner = first asserted req_i at or after rr pointer, searching upward modulo NUM_REQ.
  - apu_req_o = |req_i & !full. Request mux drives the winner's operands, op and flags combinationally.
  - apu_req_o=1 & apu_gnt_i=1: handshake; stay in ARB.
  - apu_req_o=1 & apu_gnt_i=0: register the winner as lock_id; go to LOCK.
- FSM LOCK:
  - Selection is forced to lock_id. Other requests cannot preempt it. apu_req_o = req_i[lock_id].
  - On apu_gnt_i: handshake, return to ARB.
  - req_i[lock_id] dropped without a grant (core protocol violation): set err_o, return to ARB.
- Handshake actions, all at the same clock edge:
  - gnt_o[sel] = apu_gnt_i in the same cycle (combinational).
  - Push sel into the FIFO.
  - rr pointer <= sel+1 mod NUM_REQ.
- Full: when occupancy == MAX_OUTSTANDING, apu_req_o is held 0 and no grant is given. There is no full-bypass, even when a pop happens in the same cycle.
- Response path:
  - apu_rvalid_i pops the FIFO head h. rvalid_o[h]=1 in the same cycle; all other rvalid_o bits are 0.
  - result_o and rflags_o pass apu_result_i and apu_flags_i through.
- Timing: the APU returns responses in grant order, at the earliest in the cycle after the grant. Combinational latency is 0 on both paths.
- Simultaneous push and pop: occupancy is unchanged; the head and tail pointers both advance and wrap modulo MAX_OUTSTANDING.
- apu_rvalid_i with an empty FIFO: set err_o, drive no rvalid_o, leave occupancy at 0.
- err_o clears only on reset.
- Reset mid-operation: outstanding tags are discarded. The shared APU must be reset in the same domain.

Decomposition:
- APU widths come from cv32e40p_apu_core_pkg: APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU.
- The FSM state enum (ARB, LOCK) goes in a new apu_arb_pkg.
- One sub-module: apu_tag_fifo, a synchronous FIFO parameterized by width and depth, with push/pop/full/empty/count.

Test Plan:
- Single core 0 requests with gnt tied 1 → gnt_o=01, apu_op_o=core0 op; apu_rvalid_i two cycles later → rvalid_o=01, result_o=apu_result_i.
- Cores 0 and 1 request continuously, gnt=1 every cycle → grants alternate 0,1,0,1; responses return to cores 0,1,0,1 in order.
- Both cores request, gnt held 0 for 3 cycles → selection stays locked on core 0 and apu_operands_o stays stable; grant on cycle 4 → gnt_o=01, next grant goes to core 1.
- Issue 4 grants with no response → outstanding_o=4 and apu_req_o=0 despite req_i=11. One rvalid → outstanding_o=3, request re-enabled the next cycle.
- Grant and rvalid in the same cycle at occupancy 2 → outstanding_o stays 2. Run 10 such cycles → FIFO pointers wrap with no lost or misrouted tags.
- apu_rvalid_i with FIFO empty → err_o=1 and rvalid_o=00; assert rst_ni=0 asynchronously mid-stream → all outputs 0 immediately.
